// File: rtl/debug_uart_rx.sv
// debug_uart_rx: 8N1 UART receiver for the debugger command path, valid/ready byte output with framing/overrun status.
// Define DEBUG_UART_RX_MAJORITY_EN for 2-of-3 majority sampling (adds one cycle to every decision).
module debug_uart_rx #(
  parameter int DIVIDER_TICKS = 1200,
  parameter int DATA_BITS     = 8
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 debug_uart_rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 framing_error,
  output logic                 overrun_error,
  output logic                 busy
);
  localparam int TW  = $clog2(DIVIDER_TICKS);
  localparam int BW  = $clog2(DATA_BITS + 1);
  localparam int MID = DIVIDER_TICKS / 2;
`ifdef DEBUG_UART_RX_MAJORITY_EN
  localparam int START_TICK = MID;
`else
  localparam int START_TICK = MID - 1;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t               r_state, w_next;
  logic [1:0]           r_sync;
  logic [TW-1:0]        r_tick;
  logic [BW-1:0]        r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 w_rx_s, w_bit, w_start_smp, w_tick_end;
  logic                 w_shift_en, w_deliver, w_ferr;

  assign w_rx_s      = r_sync[1];
  assign w_start_smp = r_tick == TW'(START_TICK);
  assign w_tick_end  = r_tick == TW'(DIVIDER_TICKS - 1);

  always_ff @(posedge clk_in or posedge reset)
    if (reset) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], debug_uart_rx_in};

`ifdef DEBUG_UART_RX_MAJORITY_EN
  // History holds the two previous rx_s values; the decision lands on the third sample.
  logic [1:0] r_hist;
  always_ff @(posedge clk_in or posedge reset)
    if (reset) r_hist <= 2'b11;
    else       r_hist <= {r_hist[0], w_rx_s};
  assign w_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rx_s) | (r_hist[0] & w_rx_s);
`else
  assign w_bit = w_rx_s;
`endif

  always_ff @(posedge clk_in or posedge reset)
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (!w_rx_s) w_next = START;
      START:     if (w_start_smp) w_next = w_bit ? IDLE : DATA;
      DATA:      if (w_tick_end && r_bit == BW'(DATA_BITS - 1)) w_next = STOP;
      STOP:      if (w_tick_end) w_next = w_bit ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (w_rx_s) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_comb begin
    w_shift_en = (r_state == DATA) && w_tick_end;
    w_deliver  = (r_state == STOP) && w_tick_end && w_bit;
    w_ferr     = (r_state == STOP) && w_tick_end && !w_bit;
    busy       = r_state != IDLE;
  end

  always_ff @(posedge clk_in or posedge reset)
    if (reset) begin
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_tick  <= (r_state != w_next || w_tick_end || r_state == IDLE || r_state == WAIT_IDLE) ? '0 : r_tick + 1'b1;
      r_bit   <= (r_state != DATA) ? '0 : w_tick_end ? r_bit + 1'b1 : r_bit;
      if (w_shift_en) r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
    end

  // A finished byte loads when the slot is empty or being emptied this same cycle.
  always_ff @(posedge clk_in or posedge reset)
    if (reset) begin
      data_out      <= '0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      framing_error <= w_ferr;
      if (w_deliver && (!data_valid || data_ready)) begin
        data_out   <= r_shift;
        data_valid <= 1'b1;
      end else if (data_ready) data_valid <= 1'b0;
      if (w_deliver && data_valid && !data_ready) overrun_error <= 1'b1;
    end
endmodule

// File: tb/tb_debug_uart_rx.sv
// tb_debug_uart_rx: directed bench for debug_uart_rx at 16 clocks per bit, default (single-sample) build.
module tb_debug_uart_rx;
  logic       clk_in = 1'b0, reset = 1'b1, rx = 1'b1, data_ready = 1'b0;
  logic [7:0] data_out, f0;
  logic       data_valid, framing_error, overrun_error, busy;
  int         n_checks = 0, n_fail = 0;

  debug_uart_rx #(.DIVIDER_TICKS(16), .DATA_BITS(8)) dut (
    .clk_in(clk_in), .reset(reset), .debug_uart_rx_in(rx), .data_out(data_out),
    .data_valid(data_valid), .data_ready(data_ready), .framing_error(framing_error),
    .overrun_error(overrun_error), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic tx_head(input logic [7:0] d);
    rx = 1'b0;
    cyc(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      cyc(16);
    end
  endtask

  task automatic tx_full(input logic [7:0] d);
    tx_head(d);
    rx = 1'b1;
    cyc(16);
  endtask

  initial begin
    f0 = 8'hF0;
    cyc(2);
    chk("rst_data", data_out, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_ferr", framing_error, 0);
    chk("rst_ovr", overrun_error, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    cyc(5);
    // Single byte, latency 155 cycles from the pin edge
    data_ready = 1'b1;
    tx_head(8'hA5);
    rx = 1'b1;
    cyc(10);
    chk("a5_early", data_valid, 0);
    cyc(1);
    chk("a5_valid", data_valid, 1);
    chk("a5_data", data_out, 8'hA5);
    chk("a5_ferr", framing_error, 0);
    cyc(1);
    chk("a5_drop", data_valid, 0);
    cyc(4);
    // Ready coincident with delivery of a second byte
    data_ready = 1'b0;
    tx_full(8'hAA);
    chk("aa_valid", data_valid, 1);
    chk("aa_data", data_out, 8'hAA);
    tx_head(8'hBB);
    rx = 1'b1;
    cyc(10);
    chk("aa_pending", data_out, 8'hAA);
    data_ready = 1'b1;
    cyc(1);
    data_ready = 1'b0;
    chk("bb_valid", data_valid, 1);
    chk("bb_data", data_out, 8'hBB);
    chk("bb_ovr", overrun_error, 0);
    cyc(1);
    chk("bb_hold", data_valid, 1);
    data_ready = 1'b1;
    cyc(1);
    data_ready = 1'b0;
    chk("bb_accept", data_valid, 0);
    cyc(3);
    // Framing error followed by a long break
    data_ready = 1'b1;
    tx_head(8'h55);
    rx = 1'b0;
    cyc(10);
    chk("fe_early", framing_error, 0);
    cyc(1);
    chk("fe_pulse", framing_error, 1);
    chk("fe_valid", data_valid, 0);
    chk("fe_busy", busy, 1);
    cyc(1);
    chk("fe_end", framing_error, 0);
    cyc(640);
    chk("brk_busy", busy, 1);
    rx = 1'b1;
    cyc(2);
    chk("brk_busy2", busy, 1);
    cyc(1);
    chk("brk_idle", busy, 0);
    cyc(5);
    tx_head(8'h12);
    rx = 1'b1;
    cyc(11);
    chk("r12_valid", data_valid, 1);
    chk("r12_data", data_out, 8'h12);
    cyc(5);
    // Start glitch of 3 cycles
    rx = 1'b0;
    cyc(3);
    rx = 1'b1;
    chk("gl_busy", busy, 1);
    cyc(7);
    chk("gl_busy_mid", busy, 1);
    cyc(1);
    chk("gl_idle", busy, 0);
    chk("gl_valid", data_valid, 0);
    cyc(20);
    chk("gl_quiet", data_valid, 0);
    // Overrun with two unaccepted bytes
    data_ready = 1'b0;
    tx_full(8'h3C);
    chk("ov_valid1", data_valid, 1);
    chk("ov_data1", data_out, 8'h3C);
    chk("ov_flag0", overrun_error, 0);
    tx_full(8'h81);
    chk("ov_valid2", data_valid, 1);
    chk("ov_data2", data_out, 8'h3C);
    chk("ov_flag1", overrun_error, 1);
    data_ready = 1'b1;
    cyc(1);
    data_ready = 1'b0;
    chk("ov_accept", data_valid, 0);
    chk("ov_sticky", overrun_error, 1);
    cyc(5);
    // Reset during bit 4 of 0xF0
    rx = 1'b0;
    cyc(16);
    for (int i = 0; i < 5; i++) begin
      rx = f0[i];
      cyc(i < 4 ? 16 : 8);
    end
    reset = 1'b1;
    #1;
    chk("mr_data", data_out, 0);
    chk("mr_valid", data_valid, 0);
    chk("mr_ferr", framing_error, 0);
    chk("mr_ovr", overrun_error, 0);
    chk("mr_busy", busy, 0);
    rx = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(3);
    chk("mr_idle", busy, 0);
    data_ready = 1'b1;
    tx_head(8'h0F);
    rx = 1'b1;
    cyc(10);
    chk("r0f_early", data_valid, 0);
    cyc(1);
    chk("r0f_valid", data_valid, 1);
    chk("r0f_data", data_out, 8'h0F);
    cyc(1);
    chk("r0f_drop", data_valid, 0);
    cyc(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
